// File: rtl/axi_master_arbiter.sv
// Shares one AXI4 master port between the IFU (read-only) and the LSU (read/write).
// One transaction in flight; the grant is held until the last R beat or the B handshake.
module axi_master_arbiter #(
    parameter bit RR_EN = 1'b1
) (
    input  logic        clock,
    input  logic        reset,

    // IFU read channels
    input  logic        ifu_arvalid,
    output logic        ifu_arready,
    input  logic [31:0] ifu_araddr,
    input  logic [3:0]  ifu_arid,
    input  logic [7:0]  ifu_arlen,
    input  logic [2:0]  ifu_arsize,
    input  logic [1:0]  ifu_arburst,
    output logic        ifu_rvalid,
    input  logic        ifu_rready,
    output logic [31:0] ifu_rdata,
    output logic [1:0]  ifu_rresp,
    output logic        ifu_rlast,
    output logic [3:0]  ifu_rid,

    // LSU read channels
    input  logic        lsu_arvalid,
    output logic        lsu_arready,
    input  logic [31:0] lsu_araddr,
    input  logic [3:0]  lsu_arid,
    input  logic [7:0]  lsu_arlen,
    input  logic [2:0]  lsu_arsize,
    input  logic [1:0]  lsu_arburst,
    output logic        lsu_rvalid,
    input  logic        lsu_rready,
    output logic [31:0] lsu_rdata,
    output logic [1:0]  lsu_rresp,
    output logic        lsu_rlast,
    output logic [3:0]  lsu_rid,

    // LSU write channels
    input  logic        lsu_awvalid,
    output logic        lsu_awready,
    input  logic [31:0] lsu_awaddr,
    input  logic [3:0]  lsu_awid,
    input  logic [7:0]  lsu_awlen,
    input  logic [2:0]  lsu_awsize,
    input  logic [1:0]  lsu_awburst,
    input  logic        lsu_wvalid,
    output logic        lsu_wready,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wstrb,
    input  logic        lsu_wlast,
    output logic        lsu_bvalid,
    input  logic        lsu_bready,
    output logic [1:0]  lsu_bresp,
    output logic [3:0]  lsu_bid,

    // Downstream AXI4 master port
    output logic        io_master_awvalid,
    input  logic        io_master_awready,
    output logic [31:0] io_master_awaddr,
    output logic [3:0]  io_master_awid,
    output logic [7:0]  io_master_awlen,
    output logic [2:0]  io_master_awsize,
    output logic [1:0]  io_master_awburst,
    output logic        io_master_wvalid,
    input  logic        io_master_wready,
    output logic [31:0] io_master_wdata,
    output logic [3:0]  io_master_wstrb,
    output logic        io_master_wlast,
    input  logic        io_master_bvalid,
    output logic        io_master_bready,
    input  logic [1:0]  io_master_bresp,
    input  logic [3:0]  io_master_bid,
    output logic        io_master_arvalid,
    input  logic        io_master_arready,
    output logic [31:0] io_master_araddr,
    output logic [3:0]  io_master_arid,
    output logic [7:0]  io_master_arlen,
    output logic [2:0]  io_master_arsize,
    output logic [1:0]  io_master_arburst,
    input  logic        io_master_rvalid,
    output logic        io_master_rready,
    input  logic [31:0] io_master_rdata,
    input  logic [1:0]  io_master_rresp,
    input  logic        io_master_rlast,
    input  logic [3:0]  io_master_rid
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_IFU_RD,
        S_LSU_RD,
        S_LSU_WR,
        S_LSU_B
    } state_e;

    typedef enum logic {
        GNT_IFU = 1'b0,
        GNT_LSU = 1'b1
    } gnt_e;

    state_e state_q, state_d;
    gnt_e   last_gnt_q, last_gnt_d;
    logic   ar_done_q, ar_done_d;
    logic   aw_done_q, aw_done_d;
    logic   w_done_q, w_done_d;

    logic ifu_req;
    logic lsu_req;
    logic lsu_wins;

    assign ifu_req = ifu_arvalid;
    assign lsu_req = lsu_awvalid | lsu_arvalid;

    // The LSU takes a conflict unless round-robin is on and it was the last one served.
    assign lsu_wins = lsu_req & (~ifu_req | ~RR_EN | (last_gnt_q == GNT_IFU));

    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q    <= S_IDLE;
            last_gnt_q <= GNT_IFU;
            ar_done_q  <= 1'b0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            ar_done_q  <= ar_done_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
        end
    end

    always_comb begin
        // NOTE: every next-state and output gets a default first, so no path infers a latch.
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        ar_done_d  = ar_done_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;

        ifu_arready = 1'b0;
        ifu_rvalid  = 1'b0;
        ifu_rdata   = '0;
        ifu_rresp   = '0;
        ifu_rlast   = 1'b0;
        ifu_rid     = '0;
        lsu_arready = 1'b0;
        lsu_rvalid  = 1'b0;
        lsu_rdata   = '0;
        lsu_rresp   = '0;
        lsu_rlast   = 1'b0;
        lsu_rid     = '0;
        lsu_awready = 1'b0;
        lsu_wready  = 1'b0;
        lsu_bvalid  = 1'b0;
        lsu_bresp   = '0;
        lsu_bid     = '0;

        io_master_awvalid = 1'b0;
        io_master_awaddr  = '0;
        io_master_awid    = '0;
        io_master_awlen   = '0;
        io_master_awsize  = '0;
        io_master_awburst = '0;
        io_master_wvalid  = 1'b0;
        io_master_wdata   = '0;
        io_master_wstrb   = '0;
        io_master_wlast   = 1'b0;
        io_master_bready  = 1'b0;
        io_master_arvalid = 1'b0;
        io_master_araddr  = '0;
        io_master_arid    = '0;
        io_master_arlen   = '0;
        io_master_arsize  = '0;
        io_master_arburst = '0;
        io_master_rready  = 1'b0;

        case (state_q)
            S_IDLE: begin
                ar_done_d = 1'b0;
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                if (lsu_wins) begin
                    last_gnt_d = GNT_LSU;
                    state_d    = lsu_awvalid ? S_LSU_WR : S_LSU_RD;
                end else if (ifu_req) begin
                    last_gnt_d = GNT_IFU;
                    state_d    = S_IFU_RD;
                end
            end

            S_IFU_RD: begin
                io_master_arvalid = ifu_arvalid & ~ar_done_q;
                io_master_araddr  = ifu_araddr;
                io_master_arid    = ifu_arid;
                io_master_arlen   = ifu_arlen;
                io_master_arsize  = ifu_arsize;
                io_master_arburst = ifu_arburst;
                ifu_arready       = io_master_arready & ~ar_done_q;
                ifu_rvalid        = io_master_rvalid;
                ifu_rdata         = io_master_rdata;
                ifu_rresp         = io_master_rresp;
                ifu_rlast         = io_master_rlast;
                ifu_rid           = io_master_rid;
                io_master_rready  = ifu_rready;
                if (ifu_arvalid & ~ar_done_q & io_master_arready) begin
                    ar_done_d = 1'b1;
                end
                if (io_master_rvalid & ifu_rready & io_master_rlast) begin
                    state_d = S_IDLE;
                end
            end

            S_LSU_RD: begin
                io_master_arvalid = lsu_arvalid & ~ar_done_q;
                io_master_araddr  = lsu_araddr;
                io_master_arid    = lsu_arid;
                io_master_arlen   = lsu_arlen;
                io_master_arsize  = lsu_arsize;
                io_master_arburst = lsu_arburst;
                lsu_arready       = io_master_arready & ~ar_done_q;
                lsu_rvalid        = io_master_rvalid;
                lsu_rdata         = io_master_rdata;
                lsu_rresp         = io_master_rresp;
                lsu_rlast         = io_master_rlast;
                lsu_rid           = io_master_rid;
                io_master_rready  = lsu_rready;
                if (lsu_arvalid & ~ar_done_q & io_master_arready) begin
                    ar_done_d = 1'b1;
                end
                if (io_master_rvalid & lsu_rready & io_master_rlast) begin
                    state_d = S_IDLE;
                end
            end

            S_LSU_WR: begin
                // AW and W run independently; either may finish first.
                io_master_awvalid = lsu_awvalid & ~aw_done_q;
                io_master_awaddr  = lsu_awaddr;
                io_master_awid    = lsu_awid;
                io_master_awlen   = lsu_awlen;
                io_master_awsize  = lsu_awsize;
                io_master_awburst = lsu_awburst;
                lsu_awready       = io_master_awready & ~aw_done_q;
                io_master_wvalid  = lsu_wvalid & ~w_done_q;
                io_master_wdata   = lsu_wdata;
                io_master_wstrb   = lsu_wstrb;
                io_master_wlast   = lsu_wlast;
                lsu_wready        = io_master_wready & ~w_done_q;
                if (lsu_awvalid & ~aw_done_q & io_master_awready) begin
                    aw_done_d = 1'b1;
                end
                if (lsu_wvalid & ~w_done_q & io_master_wready & lsu_wlast) begin
                    w_done_d = 1'b1;
                end
                if (aw_done_d & w_done_d) begin
                    state_d = S_LSU_B;
                end
            end

            S_LSU_B: begin
                lsu_bvalid       = io_master_bvalid;
                lsu_bresp        = io_master_bresp;
                lsu_bid          = io_master_bid;
                io_master_bready = lsu_bready;
                if (io_master_bvalid & lsu_bready) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_axi_master_arbiter.sv
// Drives two arbiters (round-robin on / LSU priority) with shared stimulus and compares
// every output group each cycle against a transaction-level reference model.
module tb_axi_master_arbiter;

    localparam int N = 2;   // instance 0: RR_EN=1, instance 1: RR_EN=0

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    // Shared inputs
    logic        ifu_arvalid, ifu_rready, lsu_arvalid, lsu_rready;
    logic [31:0] ifu_araddr, lsu_araddr;
    logic [3:0]  ifu_arid, lsu_arid;
    logic [7:0]  ifu_arlen, lsu_arlen;
    logic [2:0]  ifu_arsize, lsu_arsize;
    logic [1:0]  ifu_arburst, lsu_arburst;
    logic        lsu_awvalid, lsu_wvalid, lsu_wlast, lsu_bready;
    logic [31:0] lsu_awaddr, lsu_wdata;
    logic [3:0]  lsu_awid, lsu_wstrb;
    logic [7:0]  lsu_awlen;
    logic [2:0]  lsu_awsize;
    logic [1:0]  lsu_awburst;
    logic        io_master_awready, io_master_wready, io_master_bvalid, io_master_arready;
    logic        io_master_rvalid, io_master_rlast;
    logic [1:0]  io_master_bresp, io_master_rresp;
    logic [3:0]  io_master_bid, io_master_rid;
    logic [31:0] io_master_rdata;

    // Per-instance outputs
    logic        ifu_arready [N], ifu_rvalid [N], ifu_rlast [N];
    logic [31:0] ifu_rdata [N];
    logic [1:0]  ifu_rresp [N];
    logic [3:0]  ifu_rid [N];
    logic        lsu_arready [N], lsu_rvalid [N], lsu_rlast [N];
    logic [31:0] lsu_rdata [N];
    logic [1:0]  lsu_rresp [N];
    logic [3:0]  lsu_rid [N];
    logic        lsu_awready [N], lsu_wready [N], lsu_bvalid [N];
    logic [1:0]  lsu_bresp [N];
    logic [3:0]  lsu_bid [N];
    logic        io_master_awvalid [N], io_master_wvalid [N], io_master_wlast [N];
    logic        io_master_bready [N], io_master_arvalid [N], io_master_rready [N];
    logic [31:0] io_master_awaddr [N], io_master_wdata [N], io_master_araddr [N];
    logic [3:0]  io_master_awid [N], io_master_wstrb [N], io_master_arid [N];
    logic [7:0]  io_master_awlen [N], io_master_arlen [N];
    logic [2:0]  io_master_awsize [N], io_master_arsize [N];
    logic [1:0]  io_master_awburst [N], io_master_arburst [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        axi_master_arbiter #(.RR_EN(g == 0)) u_dut (
            .clock(clock), .reset(reset),
            .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready[g]),
            .ifu_araddr(ifu_araddr), .ifu_arid(ifu_arid), .ifu_arlen(ifu_arlen),
            .ifu_arsize(ifu_arsize), .ifu_arburst(ifu_arburst),
            .ifu_rvalid(ifu_rvalid[g]), .ifu_rready(ifu_rready),
            .ifu_rdata(ifu_rdata[g]), .ifu_rresp(ifu_rresp[g]),
            .ifu_rlast(ifu_rlast[g]), .ifu_rid(ifu_rid[g]),
            .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready[g]),
            .lsu_araddr(lsu_araddr), .lsu_arid(lsu_arid), .lsu_arlen(lsu_arlen),
            .lsu_arsize(lsu_arsize), .lsu_arburst(lsu_arburst),
            .lsu_rvalid(lsu_rvalid[g]), .lsu_rready(lsu_rready),
            .lsu_rdata(lsu_rdata[g]), .lsu_rresp(lsu_rresp[g]),
            .lsu_rlast(lsu_rlast[g]), .lsu_rid(lsu_rid[g]),
            .lsu_awvalid(lsu_awvalid), .lsu_awready(lsu_awready[g]),
            .lsu_awaddr(lsu_awaddr), .lsu_awid(lsu_awid), .lsu_awlen(lsu_awlen),
            .lsu_awsize(lsu_awsize), .lsu_awburst(lsu_awburst),
            .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready[g]),
            .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_wlast(lsu_wlast),
            .lsu_bvalid(lsu_bvalid[g]), .lsu_bready(lsu_bready),
            .lsu_bresp(lsu_bresp[g]), .lsu_bid(lsu_bid[g]),
            .io_master_awvalid(io_master_awvalid[g]), .io_master_awready(io_master_awready),
            .io_master_awaddr(io_master_awaddr[g]), .io_master_awid(io_master_awid[g]),
            .io_master_awlen(io_master_awlen[g]), .io_master_awsize(io_master_awsize[g]),
            .io_master_awburst(io_master_awburst[g]),
            .io_master_wvalid(io_master_wvalid[g]), .io_master_wready(io_master_wready),
            .io_master_wdata(io_master_wdata[g]), .io_master_wstrb(io_master_wstrb[g]),
            .io_master_wlast(io_master_wlast[g]),
            .io_master_bvalid(io_master_bvalid), .io_master_bready(io_master_bready[g]),
            .io_master_bresp(io_master_bresp), .io_master_bid(io_master_bid),
            .io_master_arvalid(io_master_arvalid[g]), .io_master_arready(io_master_arready),
            .io_master_araddr(io_master_araddr[g]), .io_master_arid(io_master_arid[g]),
            .io_master_arlen(io_master_arlen[g]), .io_master_arsize(io_master_arsize[g]),
            .io_master_arburst(io_master_arburst[g]),
            .io_master_rvalid(io_master_rvalid), .io_master_rready(io_master_rready[g]),
            .io_master_rdata(io_master_rdata), .io_master_rresp(io_master_rresp),
            .io_master_rlast(io_master_rlast), .io_master_rid(io_master_rid)
        );
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: the transaction currently owning the bus, if any.
    typedef struct packed {
        logic busy;     // a transaction owns the bus
        logic lsu;      // owner is the LSU
        logic wr;       // owner is a write
        logic addr_ok;  // AR/AW accepted
        logic data_ok;  // final W beat accepted
        logic resp;     // waiting for B
    } txn_t;

    txn_t txn [N], txn_nx [N];
    logic last_lsu [N], last_lsu_nx [N];

    task automatic model_step(input int k);
        txn_t        t, tn;
        logic        ln, src_v, src_rr, ifu_req, lsu_req;
        logic [48:0] src_pl;
        logic [49:0] e_mar, e_maw;
        logic [37:0] e_mw;
        logic [1:0]  e_rdy;
        logic [40:0] e_ifu, e_lsur, up_r;
        logic [8:0]  e_lsuw;
        t = txn[k];
        tn = t;
        ln = last_lsu[k];
        e_mar = '0; e_maw = '0; e_mw = '0; e_rdy = '0;
        e_ifu = '0; e_lsur = '0; e_lsuw = '0;
        src_v  = t.lsu ? lsu_arvalid : ifu_arvalid;
        src_rr = t.lsu ? lsu_rready : ifu_rready;
        src_pl = t.lsu ? {lsu_araddr, lsu_arid, lsu_arlen, lsu_arsize, lsu_arburst}
                       : {ifu_araddr, ifu_arid, ifu_arlen, ifu_arsize, ifu_arburst};
        if (t.busy && !t.wr) begin
            e_mar = {src_v & ~t.addr_ok, src_pl};
            up_r  = {io_master_arready & ~t.addr_ok, io_master_rvalid, io_master_rdata,
                     io_master_rresp, io_master_rlast, io_master_rid};
            if (t.lsu) e_lsur = up_r;
            else       e_ifu  = up_r;
            e_rdy = {src_rr, 1'b0};
        end else if (t.busy && !t.resp) begin
            e_maw  = {lsu_awvalid & ~t.addr_ok, lsu_awaddr, lsu_awid, lsu_awlen, lsu_awsize, lsu_awburst};
            e_mw   = {lsu_wvalid & ~t.data_ok, lsu_wdata, lsu_wstrb, lsu_wlast};
            e_lsuw = {io_master_awready & ~t.addr_ok, io_master_wready & ~t.data_ok, 7'b0};
        end else if (t.busy) begin
            e_rdy  = {1'b0, lsu_bready};
            e_lsuw = {2'b00, io_master_bvalid, io_master_bresp, io_master_bid};
        end

        check($sformatf("dut%0d.m_ar", k), {io_master_arvalid[k], io_master_araddr[k], io_master_arid[k],
              io_master_arlen[k], io_master_arsize[k], io_master_arburst[k]}, e_mar);
        check($sformatf("dut%0d.m_aw", k), {io_master_awvalid[k], io_master_awaddr[k], io_master_awid[k],
              io_master_awlen[k], io_master_awsize[k], io_master_awburst[k]}, e_maw);
        check($sformatf("dut%0d.m_w", k), {io_master_wvalid[k], io_master_wdata[k], io_master_wstrb[k],
              io_master_wlast[k]}, e_mw);
        check($sformatf("dut%0d.m_rdy", k), {io_master_rready[k], io_master_bready[k]}, e_rdy);
        check($sformatf("dut%0d.ifu", k), {ifu_arready[k], ifu_rvalid[k], ifu_rdata[k], ifu_rresp[k],
              ifu_rlast[k], ifu_rid[k]}, e_ifu);
        check($sformatf("dut%0d.lsu_r", k), {lsu_arready[k], lsu_rvalid[k], lsu_rdata[k], lsu_rresp[k],
              lsu_rlast[k], lsu_rid[k]}, e_lsur);
        check($sformatf("dut%0d.lsu_w", k), {lsu_awready[k], lsu_wready[k], lsu_bvalid[k], lsu_bresp[k],
              lsu_bid[k]}, e_lsuw);

        ifu_req = ifu_arvalid;
        lsu_req = lsu_awvalid | lsu_arvalid;
        if (reset) begin
            tn = '0;
            ln = 1'b0;
        end else if (!t.busy) begin
            if (lsu_req && (!ifu_req || k != 0 || !last_lsu[k])) begin
                tn = '0; tn.busy = 1'b1; tn.lsu = 1'b1; tn.wr = lsu_awvalid;
                ln = 1'b1;
            end else if (ifu_req) begin
                tn = '0; tn.busy = 1'b1;
                ln = 1'b0;
            end
        end else if (!t.wr) begin
            if (e_mar[49] && io_master_arready) tn.addr_ok = 1'b1;
            if (io_master_rvalid && src_rr && io_master_rlast) tn = '0;
        end else if (!t.resp) begin
            if (e_maw[49] && io_master_awready) tn.addr_ok = 1'b1;
            if (e_mw[37] && io_master_wready && lsu_wlast) tn.data_ok = 1'b1;
            if (tn.addr_ok && tn.data_ok) tn.resp = 1'b1;
        end else if (io_master_bvalid && lsu_bready) begin
            tn = '0;
        end
        txn_nx[k] = tn;
        last_lsu_nx[k] = ln;
    endtask

    task automatic sample();
        @(negedge clock);
        for (int k = 0; k < N; k++) model_step(k);
    endtask

    task automatic advance();
        @(posedge clock);
        for (int k = 0; k < N; k++) begin
            txn[k] = txn_nx[k];
            last_lsu[k] = last_lsu_nx[k];
        end
        #1;
    endtask

    task automatic cycle();
        sample();
        advance();
    endtask

    task automatic clear_inputs();
        {ifu_arvalid, ifu_rready, lsu_arvalid, lsu_rready} = '0;
        {ifu_araddr, ifu_arid, ifu_arlen, ifu_arsize, ifu_arburst} = '0;
        {lsu_araddr, lsu_arid, lsu_arlen, lsu_arsize, lsu_arburst} = '0;
        {lsu_awvalid, lsu_awaddr, lsu_awid, lsu_awlen, lsu_awsize, lsu_awburst} = '0;
        {lsu_wvalid, lsu_wdata, lsu_wstrb, lsu_wlast, lsu_bready} = '0;
        {io_master_awready, io_master_wready, io_master_arready} = '0;
        {io_master_bvalid, io_master_bresp, io_master_bid} = '0;
        {io_master_rvalid, io_master_rdata, io_master_rresp, io_master_rlast, io_master_rid} = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        cycle();
        reset = 1'b0;
    endtask

    function automatic logic chance(input int pct);
        return $urandom_range(0, 99) < pct;
    endfunction

    task automatic random_inputs();
        reset = ($urandom_range(0, 299) == 0);
        ifu_arvalid = chance(50); ifu_rready = chance(70);
        lsu_arvalid = chance(40); lsu_rready = chance(70);
        lsu_awvalid = chance(35); lsu_wvalid = chance(60);
        lsu_wlast = chance(40);   lsu_bready = chance(70);
        ifu_araddr = $urandom; ifu_arid = 4'($urandom); ifu_arlen = 8'($urandom);
        ifu_arsize = 3'($urandom); ifu_arburst = 2'($urandom);
        lsu_araddr = $urandom; lsu_arid = 4'($urandom); lsu_arlen = 8'($urandom);
        lsu_arsize = 3'($urandom); lsu_arburst = 2'($urandom);
        lsu_awaddr = $urandom; lsu_awid = 4'($urandom); lsu_awlen = 8'($urandom);
        lsu_awsize = 3'($urandom); lsu_awburst = 2'($urandom);
        lsu_wdata = $urandom; lsu_wstrb = 4'($urandom);
        io_master_awready = chance(50); io_master_wready = chance(50);
        io_master_arready = chance(50); io_master_bvalid = chance(40);
        io_master_bresp = 2'($urandom); io_master_bid = 4'($urandom);
        io_master_rvalid = chance(50); io_master_rlast = chance(35);
        io_master_rdata = $urandom; io_master_rresp = 2'($urandom); io_master_rid = 4'($urandom);
    endtask

    initial begin
        int          lsu_grants;
        logic        seen;
        int          beats;
        logic [5:0]  pat;

        for (int k = 0; k < N; k++) begin
            txn[k] = '0;
            last_lsu[k] = 1'b0;
        end
        reset = 1'b1;
        clear_inputs();
        @(posedge clock);
        #1;
        sample();
        check("reset_valids_readies", {io_master_awvalid[0], io_master_wvalid[0], io_master_arvalid[0],
              io_master_rready[0], io_master_bready[0], ifu_arready[0], lsu_arready[0],
              lsu_awready[0], lsu_wready[0], lsu_bvalid[0]}, 10'b0);
        advance();
        reset = 1'b0;

        // IFU-only fetch
        ifu_arvalid = 1'b1; ifu_araddr = 32'h3000_0000; ifu_arsize = 3'd2; ifu_arburst = 2'd1;
        sample(); check("fetch_bubble", io_master_arvalid[0], 1'b0); advance();
        sample();
        check("fetch_araddr", {io_master_arvalid[0], io_master_araddr[0]}, {1'b1, 32'h3000_0000});
        check("fetch_lsu_quiet", {lsu_arready[0], lsu_rvalid[0], lsu_awready[0], lsu_wready[0]}, 4'b0);
        advance();
        cycle();
        io_master_arready = 1'b1;
        sample(); check("fetch_arready_fwd", ifu_arready[0], 1'b1); advance();
        ifu_arvalid = 1'b0; io_master_arready = 1'b0;
        io_master_rvalid = 1'b1; io_master_rdata = 32'h0000_0413; io_master_rlast = 1'b1; ifu_rready = 1'b1;
        sample(); check("fetch_rdata", {ifu_rvalid[0], ifu_rdata[0]}, {1'b1, 32'h0000_0413}); advance();
        clear_inputs();
        sample(); check("fetch_back_idle", io_master_rready[0], 1'b0); advance();

        // Simultaneous reads after reset: LSU first, IFU at M+2, next conflict to LSU
        do_reset();
        ifu_arvalid = 1'b1; ifu_araddr = 32'h1000; lsu_arvalid = 1'b1; lsu_araddr = 32'h2000;
        cycle();
        sample();
        check("conflict1_lsu_rr1", {io_master_arvalid[0], io_master_araddr[0]}, {1'b1, 32'h2000});
        check("conflict1_lsu_rr0", {io_master_arvalid[1], io_master_araddr[1]}, {1'b1, 32'h2000});
        advance();
        io_master_arready = 1'b1; cycle();
        io_master_arready = 1'b0; lsu_arvalid = 1'b0;
        io_master_rvalid = 1'b1; io_master_rlast = 1'b1; lsu_rready = 1'b1; cycle();
        io_master_rvalid = 1'b0; io_master_rlast = 1'b0; lsu_rready = 1'b0;
        sample(); check("conflict_m1_idle", io_master_arvalid[0], 1'b0); advance();
        sample();
        check("conflict_m2_ifu", {io_master_arvalid[0], io_master_araddr[0]}, {1'b1, 32'h1000});
        advance();
        io_master_arready = 1'b1; cycle();
        ifu_arvalid = 1'b0; io_master_arready = 1'b0;
        io_master_rvalid = 1'b1; io_master_rlast = 1'b1; ifu_rready = 1'b1; cycle();
        clear_inputs(); cycle();
        ifu_arvalid = 1'b1; ifu_araddr = 32'h1004; lsu_arvalid = 1'b1; lsu_araddr = 32'h2004;
        cycle();
        sample();
        check("conflict2_lsu_rr1", {io_master_arvalid[0], io_master_araddr[0]}, {1'b1, 32'h2004});
        advance();

        // LSU write with W accepted three cycles before AW
        do_reset();
        lsu_awvalid = 1'b1; lsu_awaddr = 32'h8000_0004; lsu_awsize = 3'd2; lsu_awburst = 2'd1;
        lsu_wvalid = 1'b1; lsu_wdata = 32'hDEAD_BEEF; lsu_wstrb = 4'hF; lsu_wlast = 1'b1;
        cycle();
        io_master_wready = 1'b1;
        sample();
        check("wr_wdata", {io_master_wvalid[0], io_master_wdata[0], io_master_wstrb[0]}, {1'b1, 32'hDEAD_BEEF, 4'hF});
        check("wr_wready_fwd", lsu_wready[0], 1'b1);
        advance();
        io_master_wready = 1'b0;
        repeat (2) begin
            sample();
            check("wr_w_dropped", io_master_wvalid[0], 1'b0);
            check("wr_aw_waiting", {io_master_awvalid[0], io_master_awaddr[0]}, {1'b1, 32'h8000_0004});
            advance();
        end
        io_master_awready = 1'b1;
        sample(); check("wr_aw_hs", lsu_awready[0], 1'b1); advance();
        io_master_awready = 1'b0;
        io_master_bvalid = 1'b1; io_master_bresp = 2'b00; io_master_bid = 4'h3; lsu_bready = 1'b1;
        sample();
        check("wr_b_delivered", {lsu_bvalid[0], lsu_bresp[0], lsu_bid[0]}, {1'b1, 2'b00, 4'h3});
        check("wr_aw_not_reasserted", io_master_awvalid[0], 1'b0);
        advance();
        clear_inputs(); cycle();

        // LSU priority (instance 1): four writes win over a waiting IFU read
        do_reset();
        ifu_arvalid = 1'b1; ifu_araddr = 32'h3000_0000; io_master_arready = 1'b1;
        lsu_awvalid = 1'b1; lsu_wvalid = 1'b1; lsu_wlast = 1'b1; lsu_bready = 1'b1;
        io_master_awready = 1'b1; io_master_wready = 1'b1; io_master_bvalid = 1'b1;
        lsu_grants = 0;
        repeat (12) begin
            sample();
            check("rr0_ifu_waits", io_master_arvalid[1], 1'b0);
            if (io_master_awvalid[1]) lsu_grants++;
            advance();
        end
        check("rr0_lsu_grants", lsu_grants, 4);
        lsu_awvalid = 1'b0; lsu_wvalid = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            sample();
            if (io_master_arvalid[1] === 1'b1) seen = 1'b1;
            advance();
        end
        check("rr0_ifu_after_lsu", seen, 1'b1);

        // 4-beat IFU burst with a two-cycle rready stall
        do_reset();
        ifu_arvalid = 1'b1; ifu_araddr = 32'h3000_0100; ifu_arlen = 8'd3; ifu_arsize = 3'd2;
        cycle();
        io_master_arready = 1'b1; cycle();
        ifu_arvalid = 1'b0; io_master_arready = 1'b0; io_master_rvalid = 1'b1;
        pat = 6'b111001;
        beats = 0;
        for (int i = 0; i < 6; i++) begin
            ifu_rready = pat[i];
            io_master_rdata = 32'h100 + i;
            io_master_rlast = (beats == 3);
            sample();
            check("burst_rready_fwd", io_master_rready[0], pat[i]);
            check("burst_still_granted", ifu_rvalid[0], 1'b1);
            advance();
            if (pat[i]) beats++;
        end
        clear_inputs();
        sample(); check("burst_done_idle", io_master_rready[0], 1'b0); advance();

        // Reset while waiting in the B phase
        do_reset();
        lsu_awvalid = 1'b1; lsu_wvalid = 1'b1; lsu_wlast = 1'b1;
        io_master_awready = 1'b1; io_master_wready = 1'b1;
        cycle(); cycle();
        clear_inputs(); lsu_bready = 1'b1;
        sample(); check("b_wait_bready", io_master_bready[0], 1'b1); advance();
        reset = 1'b1; cycle();
        reset = 1'b0;
        sample(); check("b_reset_cleared", io_master_bready[0], 1'b0); advance();
        lsu_bready = 1'b0; ifu_arvalid = 1'b1; ifu_araddr = 32'h3000_0000;
        cycle();
        sample(); check("b_reset_ifu_grant", io_master_arvalid[0], 1'b1); advance();

        // Randomized traffic against the model
        clear_inputs();
        repeat (4000) begin
            random_inputs();
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/axi_master_arbiter.md
# axi_master_arbiter

Two-requester arbiter that shares the single `io_master_*` AXI4 port between the instruction-fetch unit (read-only) and the load/store unit (read and write). It sits between the IFU/LSU request ports and the SoC master port and allows one outstanding transaction at a time. The grant is held until the transaction completes: last R beat or the B response. It replaces the single fetch/execute sequencer as the owner of the bus once the IFU and LSU issue requests independently.

## Interface
- `RR_EN`, default 1. When 1, IFU and LSU alternate (round-robin) on conflicts. When 0, the LSU always wins.
- `clock`  input  1  system clock.
- `reset`  input  1  synchronous, active-high reset.
- `ifu_arvalid`/`ifu_arready`  in/out  1/1  IFU AR handshake.
- `ifu_araddr`/`ifu_arid`/`ifu_arlen`/`ifu_arsize`/`ifu_arburst`  input  32/4/8/3/2  IFU AR payload.
- `ifu_rvalid`/`ifu_rready`  out/in  1/1  IFU R handshake.
- `ifu_rdata`/`ifu_rresp`/`ifu_rlast`/`ifu_rid`  output  32/2/1/4  IFU R payload.
- `lsu_ar*`, `lsu_r*`  same set of signals and widths as the IFU read ports.
- `lsu_awvalid`/`lsu_awready`  in/out  1/1.
- `lsu_awaddr`/`lsu_awid`/`lsu_awlen`/`lsu_awsize`/`lsu_awburst`  input  32/4/8/3/2.
- `lsu_wvalid`/`lsu_wready`  in/out  1/1.
- `lsu_wdata`/`lsu_wstrb`/`lsu_wlast`  input  32/4/1.
- `lsu_bvalid`/`lsu_bready`  out/in  1/1.
- `lsu_bresp`/`lsu_bid`  output  2/4.
- `io_master_aw*`, `io_master_w*`, `io_master_b*`, `io_master_ar*`, `io_master_r*`  downstream AXI4 master signals with the same widths as above. Direction is mirrored: valids and payloads are outputs and readies are inputs on AW, W and AR; valids and payloads are inputs and readies are outputs on R and B.

## Operation
- **States:** IDLE, IFU_RD, LSU_RD, LSU_WR, LSU_B. All are registered.
- **IDLE:**
  - No downstream valid or ready is asserted. All upstream readies and valids are 0.
  - Requests: `ifu_req = ifu_arvalid`; `lsu_req = lsu_awvalid | lsu_arvalid`.
  - Within the LSU, a write (`lsu_awvalid`) is chosen over a read.
  - On conflict with `RR_EN=1`, grant the requester that was not granted last. With `RR_EN=0`, grant the LSU.
  - `last_gnt` is updated on entering a grant state. It resets to IFU, so the LSU wins the first conflict.
- **IFU_RD / LSU_RD:**
  - The granted AR channel is connected combinationally to `io_master_ar*`.
  - Register `ar_done` is set on the `io_master_arvalid & io_master_arready` handshake. Once set, `io_master_arvalid` is held at 0.
  - `io_master_r*` is routed to the granted requester and `io_master_rready` equals the granted requester's `rready`.
  - On `io_master_rvalid & rready & rlast`, go to IDLE.
- **LSU_WR:**
  - AW and W are forwarded concurrently. Register `aw_done` is set on the AW handshake. Register `w_done` is set on the W handshake with `wlast`.
  - W may complete before AW.
  - When both are done (including both completing in the same cycle), go to LSU_B.
  - After `aw_done`, `io_master_awvalid` is 0. After `w_done`, `io_master_wvalid` is 0.
- **LSU_B:** `io_master_b*` is routed to the LSU and `io_master_bready = lsu_bready`. On the B handshake, go to IDLE.
- **Non-granted requester:** all of its readies and valids are 0, so its request stays pending.
- **Pass-through:** `rresp`, `bresp` and IDs are passed unchanged. The arbiter does not check IDs or responses.
- **Downstream idle values:** payload outputs are 0 in IDLE. `io_master_bready` is asserted only in LSU_B. `io_master_rready` is asserted only in IFU_RD or LSU_RD.

## Timing
- **Reset:** state=IDLE, `ar_done`=`aw_done`=`w_done`=0, `last_gnt`=IFU. Every valid and ready output is 0 in the cycle after reset is sampled.
- **Grant latency:** a request seen in IDLE at edge N is granted at N+1, and the downstream valid is high in cycle N+1. This is a fixed one-cycle bubble.
- **Same-cycle forwarding:** upstream `arready`/`awready`/`wready` equal the downstream ready in the same cycle. R and B pass through with no added latency.
- **Back-to-back:** the transaction completes at cycle M, the state is IDLE at M+1, and the next grant is at M+2. The arbiter never overlaps two transactions.
- **Reset mid-transaction:** the arbiter returns to IDLE immediately and drops the grant. Downstream state is cleared by the same system reset.
- **Payload stability:** payloads must be held stable while valid is high. The arbiter does not register payloads.

## Test plan
- **IFU-only fetch:** `ifu_araddr`=0x30000000, slave arready after 2 cycles, rdata=0x00000413 with rlast → `io_master_araddr`=0x30000000, `ifu_rdata`=0x00000413, return to IDLE. The LSU sees no valids.
- **Simultaneous IFU read and LSU read after reset, `RR_EN=1`:** LSU granted first. IFU granted at the second idle cycle after the LSU rlast. The next conflict goes to the LSU.
- **LSU word write:** `awaddr`=0x80000004, `wdata`=0xDEADBEEF, `wstrb`=0xF, with W accepted 3 cycles before AW → state LSU_WR→LSU_B. `lsu_bresp`=0 is delivered and `io_master_awvalid` is never re-asserted.
- **Write vs. read conflict with `RR_EN=0`:** IFU read and LSU write pending together, repeated 4 times → the LSU is granted every time and the IFU waits. The IFU is granted once the LSU goes idle.
- **4-beat IFU burst (`arlen`=3):** no return to IDLE until the 4th beat with rlast. `ifu_rready` low for 2 cycles stalls `io_master_rready` in the same cycles.
- **Reset asserted in LSU_B with `bvalid`=0:** outputs are all 0 on the next cycle and state is IDLE. A fresh IFU request is then granted normally.
